fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
Next-generation EX-stage forwarding and hazard unit for the 5-stage pipeline. It handles NUM_SRC operand sources, detects load-use hazards, and adds a one-entry scoreboard for a fixed-latency long-op unit (multiplier/divider). Outputs are per-source forward selects, a pipeline stall, and long-op completion/writeback control. It sits beside the IDEX/EXMEM/MEMWB registers and drives the ALU operand muxes and the hazard-stall path.

Parameters:
REG_AW, 5, register address width; address 0 is hardwired zero
NUM_SRC, 2, number of EX-stage operand sources checked (1..4)
LONG_LAT, 4, cycles from long-op issue to result (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  EX-stage instruction is being squashed this cycle
ex_src_i  in  NUM_SRC*REG_AW  EX-stage source register addresses, source k at [k*REG_AW +: REG_AW]
ex_src_vld_i  in  NUM_SRC  source k is actually read
ex_regwrite_i  in  1  EX-stage instruction writes a register
ex_rd_i  in  REG_AW  EX-stage destination register
long_issue_i  in  1  EX-stage instruction is a long op
exmem_regwrite_i  in  1  EXMEM RegWrite
exmem_memread_i  in  1  EXMEM instruction is a load
exmem_rd_i  in  REG_AW  EXMEM destination
memwb_regwrite_i  in  1  MEMWB RegWrite
memwb_rd_i  in  REG_AW  MEMWB destination
fwd_sel_o  out  2*NUM_SRC  per-source select: 00 regfile, 01 MEMWB, 10 EXMEM, 11 long result
stall_o  out  1  hold PC/IFID/IDEX; insert bubble into EXMEM
long_busy_o  out  1  scoreboard state is BUSY
long_done_o  out  1  long result valid this cycle; long-unit writeback enable
long_rd_o  out  REG_AW  destination of the completing long op

Behaviour:
- Single clock clk_i; rst_i is synchronous and active-high.
- Reset: state IDLE, counter 0, busy_rd 0, long_busy_o 0, long_done_o 0, long_rd_o 0.
- Scoreboard FSM states are IDLE, BUSY and DONE.
  - An issue is accepted when long_issue_i=1, stall_o=0, flush_i=0, and state is IDLE or DONE.
  - On an accepted issue: latch busy_rd <= ex_rd_i (0 if !ex_regwrite_i); next state BUSY, counter <= LONG_LAT-1.
  - In BUSY the counter decrements each cycle. When it reaches 1, the next state is DONE.
  - DONE is entered exactly LONG_LAT cycles after the issue cycle and lasts one cycle. In DONE, long_done_o=1 and long_rd_o=busy_rd.
  - From DONE the next state is BUSY if a new issue is accepted that cycle, otherwise IDLE.
  - long_busy_o = (state==BUSY); it is registered.
- Forwarding (combinational), per source k with src=ex_src_i[k], applied only if ex_src_vld_i[k] and src!=0. Priority order:
  1. exmem_regwrite_i && exmem_rd_i==src && !exmem_memread_i -> 10
  2. memwb_regwrite_i && memwb_rd_i==src -> 01
  3. state==DONE && busy_rd==src && busy_rd!=0 -> 11
  4. otherwise -> 00
- stall_o (combinational) is the OR of:
  - load-use: exmem_memread_i && exmem_regwrite_i && exmem_rd_i!=0 && it matches any valid source;
  - RAW on pending: state==BUSY && busy_rd!=0 && it matches any valid source;
  - WAW: state==BUSY && ex_regwrite_i && ex_rd_i==busy_rd && busy_rd!=0;
  - structural: long_issue_i && state==BUSY.
- flush_i=1 forces stall_o=0 and blocks issue acceptance. A long op already in flight is never cancelled by flush.
- Register address 0 is never forwarded from, never stalls, and never writes back (long_done_o still pulses; the regfile ignores writes to r0).
- Reset mid-BUSY returns to IDLE next edge with no long_done_o pulse.

Optional Feature:
FWD_HAZARD_PERF_EN:
- Defined: adds outputs perf_loaduse_cnt_o[31:0] and perf_long_cnt_o[31:0]. These count cycles stalled for load-use and for any scoreboard cause (RAW/WAW/structural) respectively. Counters saturate at all-ones and clear on rst_i. A cycle with both causes increments both.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, FWD_LONG=2'b11;
  - lsb_state_e enum: IDLE, BUSY, DONE;
  - function for per-source address match.
- One sub-module, long_op_scoreboard, owns the FSM, counter, busy_rd and the done/busy outputs. The top level holds the forward priority mux (generate loop over NUM_SRC) and the stall OR-tree.

Test Plan:
- EXMEM rd=3 regwrite, MEMWB rd=3 regwrite, src0=3 -> fwd_sel[1:0]=10 (EXMEM beats MEMWB); src1=0 with exmem_rd=0 -> 00.
- Load in EXMEM rd=5, src1=5 -> stall_o=1 for one cycle; next cycle same load in MEMWB -> stall_o=0, fwd_sel[3:2]=01.
- Long issue rd=7 at cycle T, LONG_LAT=4 -> long_busy_o=1 for T+1..T+3; src0=7 stalls T+1..T+3; at T+4 long_done_o=1, long_rd_o=7, fwd_sel[1:0]=11, stall_o=0.
- Second long issue during BUSY -> stall_o=1 (structural); issue in DONE cycle -> accepted, BUSY next cycle, no IDLE gap.
- EX rd=7 regwrite while BUSY rd=7 -> stall_o=1 (WAW); same with flush_i=1 -> stall_o=0, no issue accepted.
- rst_i at T+2 of a long op -> IDLE at T+3, no long_done_o pulse; with FWD_HAZARD_PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and helpers for the EX-stage forwarding/hazard unit.
// Declares package fwd_pkg: forward-select encoding, scoreboard states, address match.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_LONG  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsb_state_e;

  // Widest register address the match helper accepts; callers zero-extend.
  localparam int MAX_AW = 16;

  // A read source hits a producer only when it is really read and the
  // address is not r0, which is never forwarded from and never stalls.
  function automatic logic addr_match(input logic              vld,
                                      input logic [MAX_AW-1:0] src,
                                      input logic [MAX_AW-1:0] rd);
    return vld && (src == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle for fwd_hazard_scoreboard; master = pipeline, slave = unit.
// Perf counter outputs exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                        flush_i;
  logic [NUM_SRC*REG_AW-1:0]   ex_src_i;
  logic [NUM_SRC-1:0]          ex_src_vld_i;
  logic                        ex_regwrite_i;
  logic [REG_AW-1:0]           ex_rd_i;
  logic                        long_issue_i;
  logic                        exmem_regwrite_i;
  logic                        exmem_memread_i;
  logic [REG_AW-1:0]           exmem_rd_i;
  logic                        memwb_regwrite_i;
  logic [REG_AW-1:0]           memwb_rd_i;
  logic [2*NUM_SRC-1:0]        fwd_sel_o;
  logic                        stall_o;
  logic                        long_busy_o;
  logic                        long_done_o;
  logic [REG_AW-1:0]           long_rd_o;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]                 perf_loaduse_cnt_o;
  logic [31:0]                 perf_long_cnt_o;
`endif

  modport master (
    output flush_i, ex_src_i, ex_src_vld_i, ex_regwrite_i, ex_rd_i, long_issue_i,
    output exmem_regwrite_i, exmem_memread_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i,
    input  fwd_sel_o, stall_o, long_busy_o, long_done_o, long_rd_o
`ifdef FWD_HAZARD_PERF_EN
    , input perf_loaduse_cnt_o, perf_long_cnt_o
`endif
  );

  modport slave (
    input  flush_i, ex_src_i, ex_src_vld_i, ex_regwrite_i, ex_rd_i, long_issue_i,
    input  exmem_regwrite_i, exmem_memread_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i,
    output fwd_sel_o, stall_o, long_busy_o, long_done_o, long_rd_o
`ifdef FWD_HAZARD_PERF_EN
    , output perf_loaduse_cnt_o, perf_long_cnt_o
`endif
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_long_op_scoreboard.sv
// One-entry scoreboard for the fixed-latency long-op unit: tracks the pending
// destination and pulses done exactly LONG_LAT cycles after an accepted issue.
module long_op_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_rd,
  output lsb_state_e        state,
  output logic [REG_AW-1:0] busy_rd,
  output logic              long_busy,
  output logic              long_done,
  output logic [REG_AW-1:0] long_rd
);

  localparam int CNT_W = $clog2(LONG_LAT) + 1;

  lsb_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [REG_AW-1:0] busy_rd_nxt;

  // NOTE: state is reset, including busy_rd, so a reset mid-op can never
  // leak a stale destination into forwarding or writeback.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_rd <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_rd <= busy_rd_nxt;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_rd_nxt = busy_rd;
    unique case (state)
      IDLE, DONE: begin
        if (issue) begin
          state_nxt   = BUSY;
          cnt_nxt     = CNT_W'(LONG_LAT - 1);
          busy_rd_nxt = issue_rd;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign long_busy = (state == BUSY);
  assign long_done = (state == DONE);
  assign long_rd   = long_done ? busy_rd : '0;

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage operand forwarding, load-use/long-op hazard stall and long-op writeback.
// Define FWD_HAZARD_PERF_EN to add saturating stall-cause performance counters.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LONG_LAT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fwd_hazard_scoreboard_if.slave  bus
);

  lsb_state_e        state;
  logic [REG_AW-1:0] busy_rd;
  logic [NUM_SRC-1:0] lu_hit, raw_hit;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic              lu_stall, waw_stall, struct_stall, long_stall;
  logic              stall, issue_accept;
  logic [REG_AW-1:0] issue_rd;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              vld;
    fwd_sel_e          sel;

    assign src = bus.ex_src_i[k*REG_AW +: REG_AW];
    assign vld = bus.ex_src_vld_i[k];

    // Loads in EXMEM have no data yet: they stall instead of forwarding.
    always_comb begin
      sel = FWD_RF;
      if (vld && (src != '0)) begin
        if (bus.exmem_regwrite_i && (bus.exmem_rd_i == src) && !bus.exmem_memread_i)
          sel = FWD_EXMEM;
        else if (bus.memwb_regwrite_i && (bus.memwb_rd_i == src))
          sel = FWD_MEMWB;
        else if ((state == DONE) && (busy_rd == src))
          sel = FWD_LONG;
      end
    end

    assign fwd_sel[2*k +: 2] = sel;
    assign lu_hit[k]  = addr_match(vld, MAX_AW'(src), MAX_AW'(bus.exmem_rd_i));
    assign raw_hit[k] = addr_match(vld, MAX_AW'(src), MAX_AW'(busy_rd));
  end

  assign lu_stall     = bus.exmem_memread_i && bus.exmem_regwrite_i && (|lu_hit);
  assign waw_stall    = (state == BUSY) && bus.ex_regwrite_i &&
                        (bus.ex_rd_i == busy_rd) && (busy_rd != '0);
  assign struct_stall = bus.long_issue_i && (state == BUSY);
  assign long_stall   = ((state == BUSY) && (|raw_hit)) || waw_stall || struct_stall;

  // A squashed EX instruction must neither hold the pipe nor start a long op.
  assign stall        = !bus.flush_i && (lu_stall || long_stall);
  assign issue_accept = bus.long_issue_i && !stall && !bus.flush_i && (state != BUSY);
  assign issue_rd     = bus.ex_regwrite_i ? bus.ex_rd_i : '0;

  long_op_scoreboard #(
    .REG_AW   (REG_AW),
    .LONG_LAT (LONG_LAT)
  ) u_sb (
    .clk       (clk_i),
    .rst       (rst_i),
    .issue     (issue_accept),
    .issue_rd  (issue_rd),
    .state     (state),
    .busy_rd   (busy_rd),
    .long_busy (bus.long_busy_o),
    .long_done (bus.long_done_o),
    .long_rd   (bus.long_rd_o)
  );

  assign bus.fwd_sel_o = fwd_sel;
  assign bus.stall_o   = stall;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_long_cnt;

  // Both counters may step in the same cycle when both causes are present.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_cnt   <= '0;
      perf_long_cnt <= '0;
    end else begin
      if (!bus.flush_i && lu_stall && (perf_lu_cnt != '1))
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (!bus.flush_i && long_stall && (perf_long_cnt != '1))
        perf_long_cnt <= perf_long_cnt + 32'd1;
    end
  end

  assign bus.perf_loaduse_cnt_o = perf_lu_cnt;
  assign bus.perf_long_cnt_o    = perf_long_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard (REG_AW=5, NUM_SRC=2, LONG_LAT=4).
// Inputs change 1 time unit after posedge; outputs are compared 2 units later.
module tb_fwd_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) bus ();

  fwd_hazard_scoreboard #(
    .REG_AW   (5),
    .NUM_SRC  (2),
    .LONG_LAT (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.flush_i          = 1'b0;
    bus.ex_src_i         = '0;
    bus.ex_src_vld_i     = '0;
    bus.ex_regwrite_i    = 1'b0;
    bus.ex_rd_i          = '0;
    bus.long_issue_i     = 1'b0;
    bus.exmem_regwrite_i = 1'b0;
    bus.exmem_memread_i  = 1'b0;
    bus.exmem_rd_i       = '0;
    bus.memwb_regwrite_i = 1'b0;
    bus.memwb_rd_i       = '0;
  endtask

  task automatic set_src(input int k, input logic [4:0] a, input logic v);
    bus.ex_src_i[k*5 +: 5] = a;
    bus.ex_src_vld_i[k]    = v;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_long(input logic [4:0] rd, input logic rw);
    bus.long_issue_i  = 1'b1;
    bus.ex_regwrite_i = rw;
    bus.ex_rd_i       = rd;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    vectors++; if (bus.long_busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.long_busy_o); end
    vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd0) begin miscompares++; $display("FAIL rst_rd: got %0d want 0", bus.long_rd_o); end
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0000) begin miscompares++; $display("FAIL rst_fwd: got %b want 0000", bus.fwd_sel_o); end
`ifdef FWD_HAZARD_PERF_EN
    vectors++; if (bus.perf_loaduse_cnt_o !== 32'd0) begin miscompares++; $display("FAIL rst_perf_lu: got %0d want 0", bus.perf_loaduse_cnt_o); end
    vectors++; if (bus.perf_long_cnt_o !== 32'd0) begin miscompares++; $display("FAIL rst_perf_long: got %0d want 0", bus.perf_long_cnt_o); end
`endif
  endtask

  task automatic test_fwd_priority();
    do_reset();
    bus.exmem_regwrite_i = 1'b1; bus.exmem_rd_i = 5'd3;
    bus.memwb_regwrite_i = 1'b1; bus.memwb_rd_i = 5'd3;
    set_src(0, 5'd3, 1'b1); set_src(1, 5'd0, 1'b1);
    settle();
    vectors++; if (bus.fwd_sel_o !== 4'b0010) begin miscompares++; $display("FAIL fwd_exmem_beats_memwb: got %b want 0010", bus.fwd_sel_o); end
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL fwd_no_stall: got %b want 0", bus.stall_o); end
    tick();
    bus.exmem_rd_i = 5'd0;
    set_src(0, 5'd0, 1'b1); set_src(1, 5'd0, 1'b1);
    settle();
    vectors++; if (bus.fwd_sel_o !== 4'b0000) begin miscompares++; $display("FAIL fwd_r0: got %b want 0000", bus.fwd_sel_o); end
    tick();
    bus.exmem_regwrite_i = 1'b0; bus.exmem_rd_i = 5'd3;
    set_src(0, 5'd3, 1'b1); set_src(1, 5'd3, 1'b0);
    settle();
    vectors++; if (bus.fwd_sel_o !== 4'b0001) begin miscompares++; $display("FAIL fwd_memwb_only: got %b want 0001", bus.fwd_sel_o); end
    tick();
    bus.exmem_regwrite_i = 1'b1; bus.exmem_rd_i = 5'd6;
    bus.memwb_regwrite_i = 1'b1; bus.memwb_rd_i = 5'd9;
    set_src(0, 5'd9, 1'b1); set_src(1, 5'd6, 1'b1);
    settle();
    vectors++; if (bus.fwd_sel_o !== 4'b1001) begin miscompares++; $display("FAIL fwd_mixed: got %b want 1001", bus.fwd_sel_o); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.exmem_regwrite_i = 1'b1; bus.exmem_memread_i = 1'b1; bus.exmem_rd_i = 5'd5;
    set_src(1, 5'd5, 1'b1);
    settle();
    vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b want 1", bus.stall_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0000) begin miscompares++; $display("FAIL lu_no_fwd: got %b want 0000", bus.fwd_sel_o); end
    tick();
    bus.exmem_regwrite_i = 1'b0; bus.exmem_memread_i = 1'b0; bus.exmem_rd_i = 5'd0;
    bus.memwb_regwrite_i = 1'b1; bus.memwb_rd_i = 5'd5;
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lu_release: got %b want 0", bus.stall_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0100) begin miscompares++; $display("FAIL lu_memwb_fwd: got %b want 0100", bus.fwd_sel_o); end
`ifdef FWD_HAZARD_PERF_EN
    vectors++; if (bus.perf_loaduse_cnt_o !== 32'd1) begin miscompares++; $display("FAIL lu_perf: got %0d want 1", bus.perf_loaduse_cnt_o); end
`endif
    tick();
    clear_inputs();
    bus.exmem_regwrite_i = 1'b1; bus.exmem_memread_i = 1'b1; bus.exmem_rd_i = 5'd5;
    set_src(1, 5'd5, 1'b0);
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lu_invalid_src: got %b want 0", bus.stall_o); end
    tick();
    bus.exmem_rd_i = 5'd0; set_src(0, 5'd0, 1'b1);
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lu_r0: got %b want 0", bus.stall_o); end
    clear_inputs();
  endtask

  task automatic test_long_op();
    do_reset();
    issue_long(5'd7, 1'b1);
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL long_issue_stall: got %b want 0", bus.stall_o); end
    tick();
    clear_inputs();
    set_src(0, 5'd7, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      settle();
      vectors++; if (bus.long_busy_o !== 1'b1) begin miscompares++; $display("FAIL long_busy_T%0d: got %b want 1", c, bus.long_busy_o); end
      vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL long_raw_T%0d: got %b want 1", c, bus.stall_o); end
      vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL long_early_done_T%0d: got %b want 0", c, bus.long_done_o); end
      tick();
    end
    settle();
    vectors++; if (bus.long_done_o !== 1'b1) begin miscompares++; $display("FAIL long_done: got %b want 1", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd7) begin miscompares++; $display("FAIL long_rd: got %0d want 7", bus.long_rd_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0011) begin miscompares++; $display("FAIL long_fwd: got %b want 0011", bus.fwd_sel_o); end
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL long_done_stall: got %b want 0", bus.stall_o); end
    vectors++; if (bus.long_busy_o !== 1'b0) begin miscompares++; $display("FAIL long_done_busy: got %b want 0", bus.long_busy_o); end
`ifdef FWD_HAZARD_PERF_EN
    vectors++; if (bus.perf_long_cnt_o !== 32'd3) begin miscompares++; $display("FAIL long_perf: got %0d want 3", bus.perf_long_cnt_o); end
    vectors++; if (bus.perf_loaduse_cnt_o !== 32'd0) begin miscompares++; $display("FAIL long_perf_lu: got %0d want 0", bus.perf_loaduse_cnt_o); end
`endif
    tick();
    settle();
    vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL long_done_one_cycle: got %b want 0", bus.long_done_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0000) begin miscompares++; $display("FAIL long_idle_fwd: got %b want 0000", bus.fwd_sel_o); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_long(5'd9, 1'b1);
    tick();
    issue_long(5'd10, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      settle();
      vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL b2b_struct_T%0d: got %b want 1", c, bus.stall_o); end
      tick();
    end
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL b2b_done_stall: got %b want 0", bus.stall_o); end
    vectors++; if (bus.long_rd_o !== 5'd9) begin miscompares++; $display("FAIL b2b_first_rd: got %0d want 9", bus.long_rd_o); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (bus.long_busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_no_gap: got %b want 1", bus.long_busy_o); end
    vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL b2b_done_drop: got %b want 0", bus.long_done_o); end
    tick(); tick(); tick();
    settle();
    vectors++; if (bus.long_done_o !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: got %b want 1", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd10) begin miscompares++; $display("FAIL b2b_second_rd: got %0d want 10", bus.long_rd_o); end
    clear_inputs();
  endtask

  task automatic test_waw_flush();
    do_reset();
    issue_long(5'd7, 1'b1);
    tick();
    clear_inputs();
    bus.ex_regwrite_i = 1'b1; bus.ex_rd_i = 5'd7;
    settle();
    vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b want 1", bus.stall_o); end
    tick();
    bus.flush_i = 1'b1; bus.long_issue_i = 1'b1;
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL waw_flush_stall: got %b want 0", bus.stall_o); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (bus.long_busy_o !== 1'b1) begin miscompares++; $display("FAIL flush_keeps_busy: got %b want 1", bus.long_busy_o); end
    tick();
    settle();
    vectors++; if (bus.long_done_o !== 1'b1) begin miscompares++; $display("FAIL flush_done: got %b want 1", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd7) begin miscompares++; $display("FAIL flush_done_rd: got %0d want 7", bus.long_rd_o); end
    tick();
    bus.flush_i = 1'b1;
    issue_long(5'd4, 1'b1);
    settle();
    vectors++; if (bus.long_busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy: got %b want 0", bus.long_busy_o); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (bus.long_busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_issue: got %b want 0", bus.long_busy_o); end
    clear_inputs();
  endtask

  task automatic test_no_regwrite_long();
    do_reset();
    issue_long(5'd7, 1'b0);
    tick();
    clear_inputs();
    set_src(0, 5'd7, 1'b1);
    settle();
    vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL nowr_no_raw: got %b want 0", bus.stall_o); end
    vectors++; if (bus.long_busy_o !== 1'b1) begin miscompares++; $display("FAIL nowr_busy: got %b want 1", bus.long_busy_o); end
    tick(); tick(); tick();
    settle();
    vectors++; if (bus.long_done_o !== 1'b1) begin miscompares++; $display("FAIL nowr_done: got %b want 1", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd0) begin miscompares++; $display("FAIL nowr_rd: got %0d want 0", bus.long_rd_o); end
    vectors++; if (bus.fwd_sel_o !== 4'b0000) begin miscompares++; $display("FAIL nowr_fwd: got %b want 0000", bus.fwd_sel_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    issue_long(5'd12, 1'b1);
    tick();
    clear_inputs();
    set_src(0, 5'd12, 1'b1);
    settle();
    vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL rmb_raw: got %b want 1", bus.stall_o); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    vectors++; if (bus.long_busy_o !== 1'b0) begin miscompares++; $display("FAIL rmb_idle: got %b want 0", bus.long_busy_o); end
    vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL rmb_no_done: got %b want 0", bus.long_done_o); end
`ifdef FWD_HAZARD_PERF_EN
    vectors++; if (bus.perf_long_cnt_o !== 32'd0) begin miscompares++; $display("FAIL rmb_perf_long: got %0d want 0", bus.perf_long_cnt_o); end
    vectors++; if (bus.perf_loaduse_cnt_o !== 32'd0) begin miscompares++; $display("FAIL rmb_perf_lu: got %0d want 0", bus.perf_loaduse_cnt_o); end
`endif
    tick();
    settle();
    vectors++; if (bus.long_done_o !== 1'b0) begin miscompares++; $display("FAIL rmb_no_late_done: got %b want 0", bus.long_done_o); end
    vectors++; if (bus.long_rd_o !== 5'd0) begin miscompares++; $display("FAIL rmb_rd: got %0d want 0", bus.long_rd_o); end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_long_op();
    test_back_to_back();
    test_waw_flush();
    test_no_regwrite_long();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
